button_step_gen: RTL and testbench
==================================

Name: button_step_gen

Overview:
Upstream front-end for the 4-bit up counter stage. It conditions a raw, bouncing, asynchronous push-button input into clean single-cycle `step` pulses, and each pulse advances the counter by one. Processing is a two-flop synchroniser, then a stability-window debouncer, then a press/auto-repeat FSM. Everything runs in the counter's clk/reset domain.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronised cycles required before the debounced level changes; must be >= 1.
- REPEAT_DELAY, default 64: cycles from the first step to the first auto-repeat step; must be >= 2.
- REPEAT_PERIOD, default 16: cycles between subsequent auto-repeat steps; must be >= 1.
- TMR_W, default 16: width of the debounce and repeat timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- btn_in, in, 1: raw button, asynchronous to clk, may bounce.
- repeat_en, in, 1: enables auto-repeat while the button is held; synchronous level.
- step, out, 1: single-cycle advance pulse to the counter.
- btn_level, out, 1: debounced button level.
- held, out, 1: high while the FSM is in a non-IDLE state.

Behaviour:
- Reset (async, active-high): sync flops, btn_level, step, held, timers = 0; FSM = IDLE. Takes effect immediately, not at the next edge.
- Synchroniser: btn_in -> s1 -> s2, two flops, no logic between them.
- Debouncer:
  - deb_cnt clears whenever s2 == btn_level.
  - Otherwise deb_cnt increments each cycle.
  - When s2 != btn_level and deb_cnt == DEBOUNCE_CYCLES-1: btn_level toggles and deb_cnt clears on that edge.
  - Latency: btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge after btn_in becomes stable, with btn_in set up before the first edge.
  - Any s2 mismatch shorter than DEBOUNCE_CYCLES cycles produces no change.
- FSM states: IDLE, DELAY, REPEAT. `step` and `held` are registered.
  - IDLE: on the debounced rise (same edge btn_level goes 1), step=1, go to DELAY, tmr=0. held=1 from that edge.
  - DELAY:
    - tmr increments each cycle.
    - When tmr == REPEAT_DELAY-1 and repeat_en=1: step=1, go to REPEAT, tmr=0. This first repeat step lands exactly REPEAT_DELAY cycles after the initial step.
  - REPEAT: tmr increments; when tmr == REPEAT_PERIOD-1: step=1, tmr=0.
  - repeat_en=0 while in DELAY or REPEAT: go to (or stay in) DELAY with tmr=0, no steps. After repeat_en returns high, the full REPEAT_DELAY is timed again.
  - Debounced fall (btn_level 1->0) from any state: go to IDLE, tmr=0, step=0, held=0 on the same edge.
  - The fall has priority over a coincident repeat step: that step is suppressed.
- step is never high for two consecutive cycles unless REPEAT_PERIOD == 1. With REPEAT_PERIOD == 1, step is held continuously during REPEAT.
- Releasing the button never generates a step.
- Timers never wrap. They are compared and cleared before reaching 2^TMR_W-1.
- Reset mid-operation:
  - All outputs drop to 0 immediately.
  - If btn_in is still high after reset release, it is re-detected as a new press.
  - The resulting step fires on the (DEBOUNCE_CYCLES+2)th edge after reset deasserts.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset with btn_in=0, run 10 cycles -> step, btn_level, held all 0; assert reset mid-cycle -> outputs 0 before the next edge.
2. repeat_en=0; btn_in 0->1 held 30 cycles, then 0 -> btn_level and step=1 at edge 6, step exactly one cycle; no further steps; btn_level and held fall 6 edges after release; no step on release.
3. Bounce: btn_in high 3 cycles, low 2, high 3, low 1, then stable high -> exactly one step, 6 edges after the final rise; 1-cycle glitches while held -> btn_level stays 1.
4. repeat_en=1; hold 40 cycles with first step at edge T -> steps at T, T+10, T+13, T+16, ... until the debounced fall; step count matches.
5. Release timed so the debounced fall coincides with a repeat step -> no step that cycle; FSM IDLE, held=0.
6. During REPEAT: drop repeat_en for 5 cycles -> no steps, next step exactly 10 cycles after re-enable. Then assert reset with btn_in held -> outputs 0 immediately; after deassert, new step at edge 6.

Source files
------------

// File: rtl/button_step_gen.sv
// button_step_gen: turns a raw, bouncing push-button into clean single-cycle
// step pulses for the 4-bit up counter, with optional auto-repeat while held.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   btn_in     in   raw button, asynchronous to clk, may bounce
//   repeat_en  in   enables auto-repeat while the button is held
//   step       out  single-cycle advance pulse (registered)
//   btn_level  out  debounced button level (registered)
//   held       out  high while the press FSM is not IDLE (registered)
module button_step_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int TMR_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic step,
    output logic btn_level,
    output logic held
);

    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_btn_level;
    logic [TMR_W-1:0] r_deb_cnt;
    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic             r_step;
    logic             r_held;

    logic w_chg;
    logic w_deb_done;
    logic w_rise;
    logic w_fall;

    // The debounced edge is known combinationally on the edge where the
    // level toggles, so the FSM reacts on that same edge.
    assign w_chg      = (r_s2 != r_btn_level);
    assign w_deb_done = w_chg && (r_deb_cnt == DEB_LAST);
    assign w_rise     = w_deb_done && !r_btn_level;
    assign w_fall     = w_deb_done && r_btn_level;

    // Two-flop synchroniser followed by the stability-window debouncer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_btn_level <= 1'b0;
            r_deb_cnt   <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            if (!w_chg) begin
                r_deb_cnt <= '0;
            end else if (w_deb_done) begin
                r_btn_level <= ~r_btn_level;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // Press / auto-repeat FSM. A debounced fall overrides everything,
    // including a repeat step due on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_step  <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_fall) begin
                r_state <= IDLE;
                r_tmr   <= '0;
                r_held  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_step  <= 1'b1;
                            r_state <= DELAY;
                            r_tmr   <= '0;
                            r_held  <= 1'b1;
                        end
                    end
                    DELAY: begin
                        if (!repeat_en) begin
                            r_tmr <= '0;
                        end else if (r_tmr == DLY_LAST) begin
                            r_step  <= 1'b1;
                            r_state <= REPEAT;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    REPEAT: begin
                        // Disabling repeat re-arms the full initial delay.
                        if (!repeat_en) begin
                            r_state <= DELAY;
                            r_tmr   <= '0;
                        end else if (r_tmr == PER_LAST) begin
                            r_step <= 1'b1;
                            r_tmr  <= '0;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tmr   <= '0;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step      = r_step;
    assign btn_level = r_btn_level;
    assign held      = r_held;

endmodule

// File: tb/tb_button_step_gen.sv
// tb_button_step_gen: directed self-checking bench for button_step_gen
// with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_step_gen;

    logic clk;
    logic reset;
    logic btn_in;
    logic repeat_en;
    logic step;
    logic btn_level;
    logic held;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    int stepcnt = 0;
    int steps[$];
    int n0;

    button_step_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .TMR_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .step     (step),
        .btn_level(btn_level),
        .held     (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ecnt++;
            if (step === 1'b1) begin
                stepcnt++;
                steps.push_back(ecnt);
            end
        end
    endtask

    task automatic clr_log();
        stepcnt = 0;
        steps.delete();
    endtask

    initial begin
        reset     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;

        // 1: reset state
        cyc(3);
        chk("rst_step", int'(step), 0);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_held", int'(held), 0);
        reset = 1'b0;
        cyc(10);
        chk("idle_step", int'(step), 0);
        chk("idle_level", int'(btn_level), 0);
        chk("idle_held", int'(held), 0);

        // 2: single press, no repeat
        clr_log();
        btn_in = 1'b1;
        cyc(5);
        chk("t2_level_e5", int'(btn_level), 0);
        chk("t2_step_e5", int'(step), 0);
        cyc(1);
        chk("t2_level_e6", int'(btn_level), 1);
        chk("t2_step_e6", int'(step), 1);
        chk("t2_held_e6", int'(held), 1);
        cyc(1);
        chk("t2_step_e7", int'(step), 0);
        chk("t2_held_e7", int'(held), 1);
        cyc(23);
        chk("t2_count_hold", stepcnt, 1);
        btn_in = 1'b0;
        cyc(5);
        chk("t2_rel_level_e5", int'(btn_level), 1);
        chk("t2_rel_held_e5", int'(held), 1);
        cyc(1);
        chk("t2_rel_level_e6", int'(btn_level), 0);
        chk("t2_rel_held_e6", int'(held), 0);
        chk("t2_rel_step_e6", int'(step), 0);
        cyc(3);
        chk("t2_count_total", stepcnt, 1);

        // 3: bounce on press, then glitches while held
        clr_log();
        btn_in = 1'b1; cyc(3);
        btn_in = 1'b0; cyc(2);
        btn_in = 1'b1; cyc(3);
        btn_in = 1'b0; cyc(1);
        chk("t3_bounce_nostep", stepcnt, 0);
        btn_in = 1'b1;
        n0 = ecnt;
        cyc(5);
        chk("t3_level_e5", int'(btn_level), 0);
        cyc(1);
        chk("t3_step_e6", int'(step), 1);
        chk("t3_step_edge", steps.size() > 0 ? steps[0] : -1, n0 + 6);
        cyc(4);
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b0; cyc(1);
            btn_in = 1'b1; cyc(4);
        end
        chk("t3_glitch_level", int'(btn_level), 1);
        chk("t3_glitch_held", int'(held), 1);
        chk("t3_count", stepcnt, 1);
        btn_in = 1'b0;
        cyc(10);
        chk("t3_rel_level", int'(btn_level), 0);

        // 4: auto-repeat, hold 41 cycles -> fall at N+47
        clr_log();
        repeat_en = 1'b1;
        btn_in = 1'b1;
        n0 = ecnt;
        cyc(41);
        btn_in = 1'b0;
        cyc(10);
        chk("t4_count", stepcnt, 12);
        for (int i = 0; i < steps.size() && i < 12; i++) begin
            chk($sformatf("t4_step%0d", i), steps[i],
                (i == 0) ? n0 + 6 : n0 + 16 + 3 * (i - 1));
        end
        chk("t4_held_end", int'(held), 0);

        // 5: debounced fall coincides with a repeat step -> suppressed
        clr_log();
        btn_in = 1'b1;
        n0 = ecnt;
        cyc(40);
        btn_in = 1'b0;
        cyc(5);
        chk("t5_held_before", int'(held), 1);
        cyc(1);
        chk("t5_step_fall", int'(step), 0);
        chk("t5_held_fall", int'(held), 0);
        chk("t5_level_fall", int'(btn_level), 0);
        cyc(4);
        chk("t5_count", stepcnt, 11);
        chk("t5_last", steps.size() > 0 ? steps[steps.size() - 1] : -1,
            n0 + 43);

        // 6: repeat_en drop during REPEAT, then reset with button held
        clr_log();
        btn_in = 1'b1;
        n0 = ecnt;
        cyc(20);
        chk("t6_count_pre", stepcnt, 3);
        repeat_en = 1'b0;
        cyc(5);
        repeat_en = 1'b1;
        cyc(9);
        chk("t6_count_gap", stepcnt, 3);
        cyc(1);
        chk("t6_step_reen", int'(step), 1);
        cyc(1);
        chk("t6_held_pre_rst", int'(held), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_step", int'(step), 0);
        chk("t6_rst_level", int'(btn_level), 0);
        chk("t6_rst_held", int'(held), 0);
        cyc(2);
        reset = 1'b0;
        clr_log();
        cyc(5);
        chk("t6_post_step_e5", int'(step), 0);
        chk("t6_post_level_e5", int'(btn_level), 0);
        cyc(1);
        chk("t6_post_step_e6", int'(step), 1);
        chk("t6_post_level_e6", int'(btn_level), 1);
        chk("t6_post_held_e6", int'(held), 1);
        btn_in = 1'b0;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
